pipe_cla_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshake.
- Generalises the 32-bit single-cycle CLA top: configurable width, configurable number of pipeline segments, an add/sub mode, and status flags (carry, signed overflow, zero).
- Sits between the ALU operand mux and the EX/MEM result path.
- Also usable standalone as a throughput-1 arithmetic unit for multi-cycle datapaths.

---
 rtl/pipe_cla_addsub.sv | 225 ++++++++++++++++++++++
 tb/tb_pipe_cla_addsub.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_cla_addsub.sv
// ---------------------------------------------------------------------------
// pipe_cla_addsub
//
// Pipelined carry-lookahead adder/subtractor with a valid/ready handshake.
// The WIDTH-bit operation is split into STAGES segments of CHUNK = WIDTH/STAGES
// bits. Each segment adds its own slice with a CHUNK-bit lookahead adder built
// from 4-bit lookahead groups, taking the carry registered by the segment
// before it. A beat accepted in cycle n produces out_valid in cycle n+STAGES.
// The final segment also registers the carry-out, signed overflow and zero
// flags.
//
// WIDTH must be an exact multiple of STAGES. STAGES may be 1..8.
//
// Optional build macro:
//   CLA_SAT_EN - when defined, a signed overflow replaces the wrapped sum
//                with the saturated value of the operand's sign. ovf still
//                reports the overflow, c_out is unchanged, and zero follows
//                the saturated value. No extra latency is added.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  unit can accept a beat this cycle
//   a          in   operand A (WIDTH)
//   b          in   operand B (WIDTH)
//   c_in       in   carry in, used only for add
//   op         in   0 = a+b+c_in, 1 = a-b (a+~b+1, c_in ignored)
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts the result
//   s          out  result (WIDTH)
//   c_out      out  carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        out  signed overflow
//   zero       out  result is all zeros
// ---------------------------------------------------------------------------
module pipe_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int CHUNK   = WIDTH / STAGES;
    localparam int NGROUPS = (CHUNK + 3) / 4;
    localparam int LAST    = STAGES - 1;
    localparam int MSB     = WIDTH - 1;

    // Per-segment pipeline registers. Each segment keeps the full operand
    // words it was handed so that later segments can pick up their slice and
    // the final segment can see the operand signs; bits below the slices
    // already consumed are never read again.
    logic [STAGES-1:0] stageValid_q;
    logic [STAGES-1:0] stageCarry_q;
    logic [WIDTH-1:0]  stageSum_q [STAGES];
    logic [WIDTH-1:0]  stageA_q   [STAGES];
    logic [WIDTH-1:0]  stageB_q   [STAGES];
    logic              ovf_q;
    logic              zero_q;

    // What each segment sees at its input: the port beat for segment 0,
    // the previous segment's registers for the rest.
    logic [STAGES-1:0] feedValid;
    logic [STAGES-1:0] feedCarry;
    logic [WIDTH-1:0]  feedSum [STAGES];
    logic [WIDTH-1:0]  feedA   [STAGES];
    logic [WIDTH-1:0]  feedB   [STAGES];

    // Next-state values produced by each segment's adder.
    logic [STAGES-1:0] stageCarry_d;
    logic [WIDTH-1:0]  stageSum_d [STAGES];
    logic              ovf_d;
    logic              zero_d;

    logic              adv;

    // CHUNK-bit carry-lookahead adder. Bits are grouped four at a time; every
    // carry inside a group is written in flattened generate/propagate form
    // from the group's carry-in, and the carry out of a full group is exactly
    // the group generate OR group propagate AND group carry-in. Only group
    // carries chain, and only within the chunk. The returned vector is the
    // chunk carry-out followed by the chunk sum.
    function automatic logic [CHUNK:0] claChunk(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             cin
    );
        logic [CHUNK-1:0] gen;
        logic [CHUNK-1:0] prop;
        logic [CHUNK:0]   carry;
        logic             term;
        logic             chain;
        gen      = x & y;
        prop     = x ^ y;
        carry    = '0;
        carry[0] = cin;
        for (int grp = 0; grp < NGROUPS; grp++) begin
            for (int i = 1; i <= 4; i++) begin
                if (grp * 4 + i <= CHUNK) begin
                    chain = carry[grp*4];
                    for (int m = grp * 4; m < grp * 4 + i; m++) begin
                        chain = chain & prop[m];
                    end
                    term = chain;
                    for (int j = grp * 4; j < grp * 4 + i; j++) begin
                        chain = gen[j];
                        for (int m = j + 1; m < grp * 4 + i; m++) begin
                            chain = chain & prop[m];
                        end
                        term = term | chain;
                    end
                    carry[grp*4+i] = term;
                end
            end
        end
        return {carry[CHUNK], prop ^ carry[CHUNK-1:0]};
    endfunction

    // The whole pipe moves together: it may advance whenever the output
    // register is empty or is being drained this cycle. Bubbles travel with
    // the pipe rather than being squeezed out.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    assign out_valid = stageValid_q[LAST];
    assign s         = stageSum_q[LAST];
    assign c_out     = stageCarry_q[LAST];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Wire up each segment's inputs. Subtraction is folded in here, at the
    // front of the pipe, by inverting B and forcing the initial carry to 1;
    // from then on every segment just adds.
    always_comb begin
        feedValid = '0;
        feedCarry = '0;
        for (int k = 0; k < STAGES; k++) begin
            feedSum[k] = '0;
            feedA[k]   = '0;
            feedB[k]   = '0;
        end
        feedValid[0] = in_valid;
        feedCarry[0] = op ? 1'b1 : c_in;
        feedA[0]     = a;
        feedB[0]     = op ? ~b : b;
        for (int k = 1; k < STAGES; k++) begin
            feedValid[k] = stageValid_q[k-1];
            feedCarry[k] = stageCarry_q[k-1];
            feedSum[k]   = stageSum_q[k-1];
            feedA[k]     = stageA_q[k-1];
            feedB[k]     = stageB_q[k-1];
        end
    end

    // Each segment adds its own slice and merges it into the partial result
    // handed down from the segments before it. The final segment also works
    // out the flags: overflow uses the effective B sign and the wrapped sum,
    // and zero is taken from whatever value is about to be registered.
    always_comb begin
        logic [CHUNK:0] chunkRes;
        chunkRes     = '0;
        stageCarry_d = '0;
        ovf_d        = 1'b0;
        zero_d       = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            chunkRes = claChunk(feedA[k][k*CHUNK +: CHUNK],
                                feedB[k][k*CHUNK +: CHUNK],
                                feedCarry[k]);
            stageSum_d[k]                  = feedSum[k];
            stageSum_d[k][k*CHUNK +: CHUNK] = chunkRes[CHUNK-1:0];
            stageCarry_d[k]                = chunkRes[CHUNK];
        end
        ovf_d = (feedA[LAST][MSB] == feedB[LAST][MSB]) &&
                (stageSum_d[LAST][MSB] != feedA[LAST][MSB]);
`ifdef CLA_SAT_EN
        if (ovf_d) begin
            stageSum_d[LAST] = feedA[LAST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
`endif
        zero_d = (stageSum_d[LAST] == '0);
    end

    // Pipeline registers. Reset clears every segment at once so in-flight
    // beats vanish immediately; otherwise all segments load together on an
    // advance and hold together on a stall, which keeps the output beat and
    // its flags steady while downstream is not ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stageValid_q <= '0;
            stageCarry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stageSum_q[k] <= '0;
                stageA_q[k]   <= '0;
                stageB_q[k]   <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            stageValid_q <= feedValid;
            stageCarry_q <= stageCarry_d;
            for (int k = 0; k < STAGES; k++) begin
                stageSum_q[k] <= stageSum_d[k];
                stageA_q[k]   <= feedA[k];
                stageB_q[k]   <= feedB[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// ---------------------------------------------------------------------------
// tb_pipe_cla_addsub
//
// Directed and streaming bench for pipe_cla_addsub at WIDTH=32, STAGES=4.
// Every accepted beat has its expected result pushed onto a queue by a small
// arithmetic model; every delivered beat is popped and compared in order.
// Directed steps additionally check exact latency, stall behaviour and
// asynchronous reset. Honours CLA_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_pipe_cla_addsub;

    localparam int W  = 32;
    localparam int ST = 4;
    localparam int RW = W + 3;

    typedef logic [RW-1:0] rw_t;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;
    logic         zero;

    exp_t sb[$];
    exp_t popped;
    int   vectors     = 0;
    int   miscompares = 0;
    int   runLen      = 0;
    int   maxRun      = 0;
    logic took;

    pipe_cla_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .op       (op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c_out    (c_out),
        .ovf      (ovf),
        .zero     (zero)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Reference arithmetic: plain wide addition of A, effective B and carry.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic opv);
        logic [W-1:0] be;
        logic         ci;
        logic [W:0]   full;
        exp_t         e;
        be   = opv ? ~bv : bv;
        ci   = opv ? 1'b1 : cv;
        full = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ci};
        e.s  = full[W-1:0];
        e.c  = full[W];
        e.v  = (av[W-1] == be[W-1]) && (e.s[W-1] != av[W-1]);
`ifdef CLA_SAT_EN
        if (e.v) e.s = av[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.z  = (e.s == '0);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input rw_t obs, input rw_t expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic expv);
        checkOutput(tag, {{(RW-1){1'b0}}, obs}, {{(RW-1){1'b0}}, expv});
    endtask

    // Scoreboard monitor, sampled mid-cycle. What it sees at a falling edge
    // is what the next rising edge will transfer.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            runLen = 0;
        end else begin
            if (out_valid) begin
                runLen++;
                if (runLen > maxRun) maxRun = runLen;
            end else begin
                runLen = 0;
            end
            if (out_valid && out_ready) begin
                checkBit("sb_nonempty", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    popped = sb.pop_front();
                    checkOutput("result", {s, c_out, ovf, zero}, popped);
                end
            end else if (out_valid && !out_ready && sb.size() > 0) begin
                checkOutput("stall_hold", {s, c_out, ovf, zero}, sb[0]);
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, c_in, op));
        end
    end

    // Present one beat right after a rising edge and hold it until accepted.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic opv);
        logic accepted;
        @(posedge clk);
        #1;
        a = av; b = bv; c_in = cv; op = opv; in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
        end
        checkBit("accept", accepted, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called one cycle after acceptance: out_valid must first show up
    // exactly STAGES cycles after the acceptance cycle.
    task automatic waitResult(input string tag, input rw_t expv);
        int lat;
        lat = 0;
        for (int i = 1; i <= ST + 3; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, "_latency"}, rw_t'(lat), rw_t'(ST));
        checkOutput({tag, "_value"}, {s, c_out, ovf, zero}, expv);
    endtask

    task automatic drainPipe(input string tag);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) break;
        end
        checkBit(tag, sb.size() == 0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; op = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_outputs", {s, c_out, ovf, zero}, '0);
        checkBit("rst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkBit("rst_in_ready", in_ready, 1'b1);

        // Simple add crossing a 16-bit boundary
        applyStimulus(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
        waitResult("add_basic", {32'h00010000, 1'b0, 1'b0, 1'b0});

        // Carry ripples through every chunk
        applyStimulus(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
        waitResult("full_chain", {32'h00000000, 1'b1, 1'b0, 1'b1});

        // Subtract with signed overflow
        applyStimulus(32'h80000000, 32'h00000001, 1'b1, 1'b1);
`ifdef CLA_SAT_EN
        waitResult("sub_ovf", {32'h80000000, 1'b1, 1'b1, 1'b0});
`else
        waitResult("sub_ovf", {32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
`endif

        // Wrap-around add of two negatives
        applyStimulus(32'h80000000, 32'h80000000, 1'b0, 1'b0);
`ifdef CLA_SAT_EN
        waitResult("wrap_add", {32'h80000000, 1'b1, 1'b1, 1'b0});
`else
        waitResult("wrap_add", {32'h00000000, 1'b1, 1'b1, 1'b1});
`endif
        drainPipe("drain_directed");

        // Back-to-back streaming of 16 random beats
        maxRun = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            a = $urandom(); b = $urandom();
            c_in = 1'($urandom_range(0, 1)); op = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drainPipe("drain_stream");
        checkOutput("stream_run", rw_t'(maxRun), rw_t'(16));

        // Back-pressure: fill the pipe with downstream stalled
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        a = $urandom(); b = $urandom(); c_in = 1'b1; op = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) begin
                a = $urandom(); b = $urandom();
                c_in = 1'($urandom_range(0, 1)); op = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkBit("bp_in_ready", in_ready, 1'b0);
            checkBit("bp_out_valid", out_valid, 1'b1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        took = 1'b0;
        for (int i = 0; i < 10 && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkBit("bp_release_accept", took, 1'b1);
        drainPipe("drain_backpressure");

        // Asynchronous reset with beats in flight
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom() | 32'h1; b = $urandom(); c_in = 1'b0; op = 1'b0;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkBit("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_outputs", {s, c_out, ovf, zero}, '0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkBit("postrst_quiet", out_valid, 1'b0);
        end
        applyStimulus(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
`ifdef CLA_SAT_EN
        waitResult("postrst", {32'h7FFFFFFF, 1'b0, 1'b1, 1'b0});
`else
        waitResult("postrst", {32'h80000000, 1'b0, 1'b1, 1'b0});
`endif
        drainPipe("drain_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
